nodf_status_tracker: RTL and testbench

Passive cycle-accurate observer for one non-dataflow HLS block's ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue) plus a simulation-end `finish` flag. It counts accepted and completed transactions, measures per-transaction latency and initiation interval, and exposes a registered status word. It sits beside the observed block in the verification/debug top and never drives the block's control signals.

---
 rtl/nodf_status_tracker_if.sv | 21 ++
 rtl/nodf_status_tracker.sv | 190 +++++++++++++++++++
 tb/tb_nodf_status_tracker.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/nodf_status_tracker_if.sv
// ---------------------------------------------------------------------------
// nodf_status_tracker_if
// Groups the ap_ctrl handshake of one non-dataflow HLS block so that the
// status tracker can watch it.
//   ap_start    : start request towards the block
//   ap_ready    : block accepts its inputs this cycle
//   ap_done     : block produces a result this cycle
//   ap_continue : downstream accepts the result
// Modports:
//   master : the side that drives the handshake (block/harness)
//   slave  : a passive observer that only samples it
// ---------------------------------------------------------------------------
interface nodf_status_tracker_if;
    logic ap_start;
    logic ap_ready;
    logic ap_done;
    logic ap_continue;

    modport master (output ap_start, output ap_ready, output ap_done, output ap_continue);
    modport slave  (input  ap_start, input  ap_ready, input  ap_done, input  ap_continue);
endinterface

// File: rtl/nodf_status_tracker.sv
// ---------------------------------------------------------------------------
// nodf_status_tracker
// Passive observer of one HLS block's ap_ctrl handshake. Counts start
// handshakes (ap_start & ap_ready) and completions (ap_done & ap_continue),
// keeps start timestamps in a small FIFO to measure per-transaction latency,
// measures the start-to-start interval and publishes a registered status.
// Ports:
//   clock, reset (async, active-low)
//   hs            : handshake interface, observed only
//   finish        : end-of-run flag, freezes the tracker once sampled high
//   status        : 0 IDLE, 1 BUSY, 2 HOLD, 3 FINISHED
//   start_evt/done_evt : one-cycle pulses per handshake
//   txn_started/txn_done/in_flight/cycle_cnt : counters
//   last_latency/max_latency/last_interval   : timing measurements
//   overflow/underflow : sticky error flags
// All outputs are registered and lag the sampled inputs by one cycle.
// ---------------------------------------------------------------------------
module nodf_status_tracker #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    nodf_status_tracker_if.slave       hs,
    input  logic                       finish,
    output logic [1:0]                 status,
    output logic                       start_evt,
    output logic                       done_evt,
    output logic [CNT_W-1:0]           txn_started,
    output logic [CNT_W-1:0]           txn_done,
    output logic [$clog2(DEPTH):0]     in_flight,
    output logic [CNT_W-1:0]           cycle_cnt,
    output logic [CNT_W-1:0]           last_latency,
    output logic [CNT_W-1:0]           max_latency,
    output logic [CNT_W-1:0]           last_interval,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_FINISHED = 2'd3
    } status_t;

    status_t              status_r;
    logic                 start_evt_r;
    logic                 done_evt_r;
    logic [CNT_W-1:0]     txn_started_r;
    logic [CNT_W-1:0]     txn_done_r;
    logic [OCC_W-1:0]     occ_r;
    logic [CNT_W-1:0]     cycle_cnt_r;
    logic [CNT_W-1:0]     last_latency_r;
    logic [CNT_W-1:0]     max_latency_r;
    logic [CNT_W-1:0]     last_interval_r;
    logic                 overflow_r;
    logic                 underflow_r;
    logic [CNT_W-1:0]     prev_start_r;
    logic                 have_prev_r;
    logic [CNT_W-1:0]     ts_mem_r [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;

    logic                 s_hs_s;
    logic                 c_hs_s;
    logic                 frozen_s;
    logic                 empty_s;
    logic                 full_s;
    logic                 pop_s;
    logic                 push_s;
    logic                 lat_upd_s;
    logic [CNT_W-1:0]     latency_s;
    logic [OCC_W-1:0]     occ_nxt_s;
    status_t              status_nxt_s;

    // Handshake decode, FIFO control and next status.
    always_comb begin
        s_hs_s    = hs.ap_start & hs.ap_ready;
        c_hs_s    = hs.ap_done & hs.ap_continue;
        frozen_s  = finish | (status_r == ST_FINISHED);
        empty_s   = (occ_r == {OCC_W{1'b0}});
        full_s    = (occ_r == OCC_W'(DEPTH));
        pop_s     = c_hs_s & ~empty_s;
        // Start+completion on an empty FIFO is a zero-latency pass-through:
        // nothing is stored. When full, a push is only possible if a pop frees a slot.
        push_s    = s_hs_s & ~(c_hs_s & empty_s) & (~full_s | pop_s);
        lat_upd_s = pop_s | (c_hs_s & s_hs_s & empty_s);
        if (pop_s) begin
            latency_s = cycle_cnt_r - ts_mem_r[rd_ptr_r];
        end else begin
            latency_s = {CNT_W{1'b0}};
        end
        occ_nxt_s = occ_r + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
        if (frozen_s) begin
            status_nxt_s = ST_FINISHED;
        end else if (hs.ap_done & ~hs.ap_continue) begin
            status_nxt_s = ST_HOLD;
        end else if (occ_nxt_s != {OCC_W{1'b0}}) begin
            status_nxt_s = ST_BUSY;
        end else begin
            status_nxt_s = ST_IDLE;
        end
    end

    // Tracker state: counters, timestamp FIFO, measurements and flags.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            status_r        <= ST_IDLE;
            start_evt_r     <= 1'b0;
            done_evt_r      <= 1'b0;
            txn_started_r   <= {CNT_W{1'b0}};
            txn_done_r      <= {CNT_W{1'b0}};
            occ_r           <= {OCC_W{1'b0}};
            cycle_cnt_r     <= {CNT_W{1'b0}};
            last_latency_r  <= {CNT_W{1'b0}};
            max_latency_r   <= {CNT_W{1'b0}};
            last_interval_r <= {CNT_W{1'b0}};
            overflow_r      <= 1'b0;
            underflow_r     <= 1'b0;
            prev_start_r    <= {CNT_W{1'b0}};
            have_prev_r     <= 1'b0;
            wr_ptr_r        <= {PTR_W{1'b0}};
            rd_ptr_r        <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem_r[i] <= {CNT_W{1'b0}};
            end
        end else if (frozen_s) begin
            // Terminal state: everything holds, only the pulses drop.
            status_r    <= status_nxt_s;
            start_evt_r <= 1'b0;
            done_evt_r  <= 1'b0;
        end else begin
            status_r    <= status_nxt_s;
            start_evt_r <= s_hs_s;
            done_evt_r  <= c_hs_s;
            occ_r       <= occ_nxt_s;
            if (cycle_cnt_r != {CNT_W{1'b1}}) begin
                cycle_cnt_r <= cycle_cnt_r + CNT_W'(1'b1);
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (s_hs_s) begin
                txn_started_r <= txn_started_r + CNT_W'(1'b1);
                prev_start_r  <= cycle_cnt_r;
                have_prev_r   <= 1'b1;
                if (have_prev_r) begin
                    last_interval_r <= cycle_cnt_r - prev_start_r;
                end
            end
            if (c_hs_s) begin
                txn_done_r <= txn_done_r + CNT_W'(1'b1);
            end
            if (push_s) begin
                ts_mem_r[wr_ptr_r] <= cycle_cnt_r;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            if (lat_upd_s) begin
                last_latency_r <= latency_s;
                if (latency_s > max_latency_r) begin
                    max_latency_r <= latency_s;
                end
            end
            if (s_hs_s & full_s & ~c_hs_s) begin
                overflow_r <= 1'b1;
            end
            if (c_hs_s & empty_s & ~s_hs_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    assign status        = status_r;
    assign start_evt     = start_evt_r;
    assign done_evt      = done_evt_r;
    assign txn_started   = txn_started_r;
    assign txn_done      = txn_done_r;
    assign in_flight     = occ_r;
    assign cycle_cnt     = cycle_cnt_r;
    assign last_latency  = last_latency_r;
    assign max_latency   = max_latency_r;
    assign last_interval = last_interval_r;
    assign overflow      = overflow_r;
    assign underflow     = underflow_r;
endmodule

// File: tb/tb_nodf_status_tracker.sv
// ---------------------------------------------------------------------------
// tb_nodf_status_tracker
// Directed-vector bench for nodf_status_tracker. Inputs are driven 1 ns after
// a rising edge; outputs are checked at the same point, i.e. they show the
// effect of the inputs sampled at the edge just passed. "Cycle k" means the
// cycle in which cycle_cnt reads k.
// ---------------------------------------------------------------------------
module tb_nodf_status_tracker;
    localparam int CNT_W = 32;
    localparam int DEPTH = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   finish = 1'b0;
    logic [1:0]             status;
    logic                   start_evt;
    logic                   done_evt;
    logic [CNT_W-1:0]       txn_started;
    logic [CNT_W-1:0]       txn_done;
    logic [$clog2(DEPTH):0] in_flight;
    logic [CNT_W-1:0]       cycle_cnt;
    logic [CNT_W-1:0]       last_latency;
    logic [CNT_W-1:0]       max_latency;
    logic [CNT_W-1:0]       last_interval;
    logic                   overflow;
    logic                   underflow;

    int checks = 0;
    int errors = 0;
    int peak   = 0;

    nodf_status_tracker_if hs_if ();

    nodf_status_tracker #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .hs            (hs_if),
        .finish        (finish),
        .status        (status),
        .start_evt     (start_evt),
        .done_evt      (done_evt),
        .txn_started   (txn_started),
        .txn_done      (txn_done),
        .in_flight     (in_flight),
        .cycle_cnt     (cycle_cnt),
        .last_latency  (last_latency),
        .max_latency   (max_latency),
        .last_interval (last_interval),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic dn, input logic ct);
        hs_if.ap_start    = st;
        hs_if.ap_ready    = rd;
        hs_if.ap_done     = dn;
        hs_if.ap_continue = ct;
    endtask

    // Leaves the bench 1 ns after reset release, in cycle 0.
    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        finish = 1'b0;
        reset  = 1'b0;
        #12;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        // Idle after reset.
        do_reset();
        check("rst_status", 32'(status), 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_started", txn_started, 32'd0);
        repeat (9) tick();
        check("idle_cycle9", cycle_cnt, 32'd9);
        check("idle_status", 32'(status), 32'd0);
        check("idle_done", txn_done, 32'd0);

        // Single transaction: S at cycle 2, C at cycle 7.
        do_reset();
        tick();
        tick();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check("single_start_evt", 32'(start_evt), 32'd1);
        check("single_started", txn_started, 32'd1);
        check("single_busy3", 32'(status), 32'd1);
        check("single_inflight", 32'(in_flight), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (4) tick();
        check("single_cycle7", cycle_cnt, 32'd7);
        check("single_busy7", 32'(status), 32'd1);
        check("single_start_evt_low", 32'(start_evt), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("single_done_evt", 32'(done_evt), 32'd1);
        check("single_last_lat", last_latency, 32'd5);
        check("single_max_lat", max_latency, 32'd5);
        check("single_done", txn_done, 32'd1);
        check("single_idle", 32'(status), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("single_done_evt_low", 32'(done_evt), 32'd0);

        // Pipelined: S at 0,3,6 and C at 4,7,10.
        do_reset();
        peak = 0;
        for (int c = 0; c <= 10; c++) begin
            drive((c == 0) || (c == 3) || (c == 6), 1'b1,
                  (c == 4) || (c == 7) || (c == 10), 1'b1);
            tick();
            if (int'(in_flight) > peak) peak = int'(in_flight);
            if ((c == 4) || (c == 7) || (c == 10)) check("pipe_lat", last_latency, 32'd4);
            if (c == 3) check("pipe_interval3", last_interval, 32'd3);
            if (c == 0) check("pipe_interval_first", last_interval, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        check("pipe_peak", 32'(peak), 32'd2);
        check("pipe_started", txn_started, 32'd3);
        check("pipe_done", txn_done, 32'd3);
        check("pipe_max", max_latency, 32'd4);
        check("pipe_interval", last_interval, 32'd3);
        check("pipe_inflight", 32'(in_flight), 32'd0);
        check("pipe_idle", 32'(status), 32'd0);

        // Backpressure: done held with continue low for 3 cycles.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_status", 32'(status), 32'd2);
            check("hold_done", txn_done, 32'd0);
        end
        check("hold_done_evt", 32'(done_evt), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("hold_release_done", txn_done, 32'd1);
        check("hold_release_evt", 32'(done_evt), 32'd1);
        check("hold_release_lat", last_latency, 32'd4);
        check("hold_release_idle", 32'(status), 32'd0);

        // Overflow: five starts, no completions.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ovf_start_evt", 32'(start_evt), 32'd1);
            if (i == 3) begin
                check("ovf_inflight4", 32'(in_flight), 32'd4);
                check("ovf_not_yet", 32'(overflow), 32'd0);
            end
        end
        check("ovf_started", txn_started, 32'd5);
        check("ovf_inflight", 32'(in_flight), 32'd4);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_no_underflow", 32'(underflow), 32'd0);
        check("ovf_busy", 32'(status), 32'd1);
        // Start and completion together while full: oldest (cycle 0) popped at cycle 5.
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("full_sc_lat", last_latency, 32'd5);
        check("full_sc_inflight", 32'(in_flight), 32'd4);
        check("full_sc_started", txn_started, 32'd6);
        check("full_sc_done", txn_done, 32'd1);

        // Underflow, then start+completion on an empty FIFO.
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check("unf_flag", 32'(underflow), 32'd1);
        check("unf_done", txn_done, 32'd1);
        check("unf_inflight", 32'(in_flight), 32'd0);
        check("unf_no_overflow", 32'(overflow), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check("empty_sc_started", txn_started, 32'd1);
        check("empty_sc_done", txn_done, 32'd2);
        check("empty_sc_inflight", 32'(in_flight), 32'd0);
        check("empty_sc_evts", 32'({start_evt, done_evt}), 32'd3);
        check("empty_sc_lat", last_latency, 32'd0);

        // Finish freezes the tracker; reset clears it.
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        finish = 1'b1;
        tick();
        check("fin_status", 32'(status), 32'd3);
        check("fin_cycle", cycle_cnt, 32'd1);
        finish = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        check("fin_status_held", 32'(status), 32'd3);
        check("fin_started", txn_started, 32'd1);
        check("fin_done", txn_done, 32'd0);
        check("fin_cycle_frozen", cycle_cnt, 32'd1);
        check("fin_evt", 32'({start_evt, done_evt}), 32'd0);
        check("fin_inflight", 32'(in_flight), 32'd1);
        reset = 1'b0;
        #2;
        check("async_rst_status", 32'(status), 32'd0);
        check("async_rst_started", txn_started, 32'd0);
        check("async_rst_inflight", 32'(in_flight), 32'd0);
        check("async_rst_cycle", cycle_cnt, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        tick();
        check("post_rst_cycle", cycle_cnt, 32'd1);
        check("post_rst_status", 32'(status), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
